csr_bridge: RTL and testbench

CSR_BRIDGE -- requirements
Module: csr_bridge

---
 rtl/csr_bridge_if.sv | 22 ++
 rtl/csr_bridge.sv | 143 ++++++++++++++
 tb/tb_csr_bridge.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/csr_bridge_if.sv
// Wishbone classic slave-side bundle for the CSR bridge.
// The bridge takes the slave modport; the bus initiator takes the master modport.
interface csr_bridge_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_we_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
    output wb_dat_o, wb_ack_o
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
    input  wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/csr_bridge.sv
// Wishbone classic slave to CSR bus initiator, one transaction at a time.
// Partial writes become a read-modify-write so the slave always sees full words.
module csr_bridge #(
  parameter int unsigned READ_LAT = 1
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  csr_bridge_if.slave  wb,
  output logic [13:0]  csr_a,
  output logic         csr_we,
  output logic [31:0]  csr_do,
  input  logic [31:0]  csr_di
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, ACK} state_e;

  localparam logic [1:0] LAST_CNT = 2'(READ_LAT - 1);

  state_e      state_q, state_d;
  logic [13:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  logic        we_q, we_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] rd_q, rd_d;
  logic [31:0] do_q, do_d;
  logic        csr_we_q, csr_we_d;
  logic        ack_q, ack_d;

  // Only the word address reaches the CSR bus.
  logic unused_adr_bits;
  assign unused_adr_bits = ^{wb.wb_adr_i[31:16], wb.wb_adr_i[1:0]};

  function automatic logic [31:0] merge_bytes(input logic [31:0] wr,
                                              input logic [3:0]  sel,
                                              input logic [31:0] rd);
    logic [31:0] m;
    m = rd;
    for (int n = 0; n < 4; n++) begin
      if (sel[n]) m[8*n +: 8] = wr[8*n +: 8];
    end
    return m;
  endfunction

  always_comb begin
    // NOTE: every _d gets a default first so no path through the case infers a latch.
    state_d  = state_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    sel_d    = sel_q;
    we_d     = we_q;
    cnt_d    = cnt_q;
    rd_d     = rd_q;
    do_d     = do_q;
    csr_we_d = 1'b0;
    ack_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (wb.wb_cyc_i && wb.wb_stb_i) begin
          adr_d = wb.wb_adr_i[15:2];
          dat_d = wb.wb_dat_i;
          sel_d = wb.wb_sel_i;
          we_d  = wb.wb_we_i;
          cnt_d = '0;
          if (!wb.wb_we_i || (wb.wb_sel_i != 4'h0 && wb.wb_sel_i != 4'hF)) begin
            state_d = READ;
          end else if (wb.wb_sel_i == 4'hF) begin
            state_d  = WRITE;
            csr_we_d = 1'b1;
            do_d     = wb.wb_dat_i;
          end else begin
            state_d = ACK;
            ack_d   = 1'b1;
          end
        end
      end
      READ: begin
        if (!wb.wb_cyc_i) begin
          state_d = IDLE;
        end else if (cnt_q == LAST_CNT) begin
          rd_d = csr_di;
          if (we_q) begin
            state_d  = WRITE;
            csr_we_d = 1'b1;
            do_d     = merge_bytes(dat_q, sel_q, csr_di);
          end else begin
            state_d = ACK;
            ack_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      // The strobe already went out on entry; a dropped cycle only suppresses the ack.
      WRITE: begin
        if (wb.wb_cyc_i) begin
          state_d = ACK;
          ack_d   = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q  <= IDLE;
      adr_q    <= '0;
      dat_q    <= '0;
      sel_q    <= '0;
      we_q     <= 1'b0;
      cnt_q    <= '0;
      rd_q     <= '0;
      do_q     <= '0;
      csr_we_q <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking updates keep every flop sampling pre-edge values.
      state_q  <= state_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      sel_q    <= sel_d;
      we_q     <= we_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      do_q     <= do_d;
      csr_we_q <= csr_we_d;
      ack_q    <= ack_d;
    end
  end

  assign csr_a       = adr_q;
  assign csr_we      = csr_we_q;
  assign csr_do      = do_q;
  assign wb.wb_ack_o = ack_q;
  // Read data is only exposed during the ack of a read; writes return zero.
  assign wb.wb_dat_o = (ack_q && !we_q) ? rd_q : '0;

endmodule

// File: tb/tb_csr_bridge.sv
// Directed bench for csr_bridge: one instance at READ_LAT=1, one at READ_LAT=3.
// A small CSR slave model answers reads; monitors count csr_we and ack pulses.
module tb_csr_bridge;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  csr_bridge_if wb1();
  csr_bridge_if wb3();

  logic [13:0] a1, a3;
  logic        we1, we3;
  logic [31:0] do1, do3, di1, di3;

  function automatic logic [31:0] slave_rd(input logic [13:0] a);
    case (a)
      14'd4:   return 32'h1234_5678;
      14'd6:   return 32'hAABB_CCDD;
      default: return {18'h0, a};
    endcase
  endfunction

  assign di1 = slave_rd(a1);
  assign di3 = slave_rd(a3);

  csr_bridge #(.READ_LAT(1)) dut1 (
    .sys_clk(clk), .sys_rst(rst), .wb(wb1.slave),
    .csr_a(a1), .csr_we(we1), .csr_do(do1), .csr_di(di1)
  );

  csr_bridge #(.READ_LAT(3)) dut3 (
    .sys_clk(clk), .sys_rst(rst), .wb(wb3.slave),
    .csr_a(a3), .csr_we(we3), .csr_do(do3), .csr_di(di3)
  );

  int          n_pass  = 0;
  int          n_total = 0;
  int          ack_cnt[2] = '{0, 0};
  int          we_cnt[2]  = '{0, 0};
  logic [31:0] last_do[2] = '{32'h0, 32'h0};
  int          zero_viol  = 0;

  always @(posedge clk) begin
    if (wb1.wb_ack_o) ack_cnt[0]++;
    if (wb3.wb_ack_o) ack_cnt[1]++;
    if (we1) begin we_cnt[0]++; last_do[0] = do1; end
    if (we3) begin we_cnt[1]++; last_do[1] = do3; end
    if (!wb1.wb_ack_o && wb1.wb_dat_o != 32'h0) zero_viol++;
    if (!wb3.wb_ack_o && wb3.wb_dat_o != 32'h0) zero_viol++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bus(input int d, input logic cyc, input logic stb, input logic we,
                         input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    if (d == 0) begin
      wb1.wb_cyc_i = cyc; wb1.wb_stb_i = stb; wb1.wb_we_i = we;
      wb1.wb_adr_i = adr; wb1.wb_dat_i = dat; wb1.wb_sel_i = sel;
    end else begin
      wb3.wb_cyc_i = cyc; wb3.wb_stb_i = stb; wb3.wb_we_i = we;
      wb3.wb_adr_i = adr; wb3.wb_dat_i = dat; wb3.wb_sel_i = sel;
    end
  endtask

  // Latency counts clock edges from the one that samples the strobe; -1 means no ack.
  task automatic do_txn(input int d, input logic we, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel,
                        output int lat, output logic [31:0] rdata);
    lat   = -1;
    rdata = 32'hxxxx_xxxx;
    set_bus(d, 1'b1, 1'b1, we, adr, dat, sel);
    for (int i = 1; i <= 20; i++) begin
      tick();
      if ((d == 0) ? wb1.wb_ack_o : wb3.wb_ack_o) begin
        lat   = i;
        rdata = (d == 0) ? wb1.wb_dat_o : wb3.wb_dat_o;
        break;
      end
    end
    set_bus(d, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          lat;
    logic [31:0] rd;
    int          w0, k0;

    set_bus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_bus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    rst = 1'b1;
    tick();
    tick();
    check("rst_ack",    32'(wb1.wb_ack_o), 32'h0);
    check("rst_dat_o",  wb1.wb_dat_o,      32'h0);
    check("rst_csr_we", 32'(we1),          32'h0);
    check("rst_csr_a",  32'(a1),           32'h0);
    check("rst_csr_do", do1,               32'h0);
    rst = 1'b0;
    tick();

    // Full write, stepped by hand to see each cycle.
    set_bus(0, 1'b1, 1'b1, 1'b1, 32'h0000_0008, 32'h0000_000A, 4'hF);
    tick();
    check("fw_csr_a",   32'(a1), 32'h2);
    check("fw_csr_we",  32'(we1), 32'h1);
    check("fw_csr_do",  do1, 32'h0000_000A);
    check("fw_no_ack",  32'(wb1.wb_ack_o), 32'h0);
    tick();
    check("fw_ack",     32'(wb1.wb_ack_o), 32'h1);
    check("fw_dat_o",   wb1.wb_dat_o, 32'h0);
    check("fw_we_done", 32'(we1), 32'h0);
    set_bus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    check("fw_ack_pulse", 32'(wb1.wb_ack_o), 32'h0);
    tick();

    // Read at READ_LAT=1.
    w0 = we_cnt[0];
    do_txn(0, 1'b0, 32'h0000_0010, 32'h0, 4'h0, lat, rd);
    check("rd_lat",   32'(lat), 32'd2);
    check("rd_data",  rd, 32'h1234_5678);
    check("rd_no_we", 32'(we_cnt[0] - w0), 32'd0);

    // Partial write merges with the slave's current word.
    w0 = we_cnt[0];
    do_txn(0, 1'b1, 32'h0000_0018, 32'h0000_1100, 4'b0010, lat, rd);
    check("pw_lat",    32'(lat), 32'd3);
    check("pw_we_cnt", 32'(we_cnt[0] - w0), 32'd1);
    check("pw_do",     last_do[0], 32'hAABB_11DD);
    check("pw_dat_o",  rd, 32'h0);

    // Write with no byte lanes: immediate ack, no CSR access.
    w0 = we_cnt[0];
    do_txn(0, 1'b1, 32'h0000_000C, 32'hFFFF_FFFF, 4'h0, lat, rd);
    check("s0_lat",   32'(lat), 32'd1);
    check("s0_no_we", 32'(we_cnt[0] - w0), 32'd0);
    check("s0_dat_o", rd, 32'h0);

    // Junk in address bits [31:16] and [1:0].
    do_txn(0, 1'b0, 32'hFFFF_0013, 32'h0, 4'h0, lat, rd);
    check("ub_lat",   32'(lat), 32'd2);
    check("ub_data",  rd, 32'h1234_5678);
    check("ub_csr_a", 32'(a1), 32'h4);

    // Cycle dropped while in WRITE: strobe completes, no ack.
    w0 = we_cnt[0];
    k0 = ack_cnt[0];
    set_bus(0, 1'b1, 1'b1, 1'b1, 32'h0000_0020, 32'h0000_0055, 4'hF);
    tick();
    set_bus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (4) tick();
    check("wd_we_cnt", 32'(we_cnt[0] - w0), 32'd1);
    check("wd_no_ack", 32'(ack_cnt[0] - k0), 32'd0);
    check("wd_do",     last_do[0], 32'h0000_0055);

    // Strobe held through ACK yields a second transaction.
    k0 = ack_cnt[0];
    set_bus(0, 1'b1, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'h0);
    repeat (5) tick();
    set_bus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    check("b2b_acks", 32'(ack_cnt[0] - k0), 32'd2);

    // Reset pulse while in READ aborts the transaction.
    w0 = we_cnt[0];
    k0 = ack_cnt[0];
    set_bus(0, 1'b1, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'h0);
    tick();
    #1 rst = 1'b1;
    #1;
    check("mr_ack",    32'(wb1.wb_ack_o), 32'h0);
    check("mr_dat_o",  wb1.wb_dat_o, 32'h0);
    check("mr_csr_we", 32'(we1), 32'h0);
    check("mr_csr_a",  32'(a1), 32'h0);
    check("mr_csr_do", do1, 32'h0);
    set_bus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check("mr_no_ack", 32'(ack_cnt[0] - k0), 32'd0);
    check("mr_no_we",  32'(we_cnt[0] - w0), 32'd0);
    do_txn(0, 1'b0, 32'h0000_0010, 32'h0, 4'h0, lat, rd);
    check("mr_rd_lat",  32'(lat), 32'd2);
    check("mr_rd_data", rd, 32'h1234_5678);

    // READ_LAT=3 instance.
    do_txn(1, 1'b0, 32'h0000_0010, 32'h0, 4'h0, lat, rd);
    check("l3_rd_lat",  32'(lat), 32'd4);
    check("l3_rd_data", rd, 32'h1234_5678);
    do_txn(1, 1'b1, 32'h0000_0018, 32'h0000_1100, 4'b0010, lat, rd);
    check("l3_pw_lat", 32'(lat), 32'd5);
    check("l3_pw_do",  last_do[1], 32'hAABB_11DD);

    w0 = we_cnt[1];
    k0 = ack_cnt[1];
    set_bus(1, 1'b1, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'h0);
    tick();
    tick();
    set_bus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (5) tick();
    check("l3_cd_no_ack", 32'(ack_cnt[1] - k0), 32'd0);
    check("l3_cd_no_we",  32'(we_cnt[1] - w0), 32'd0);
    // Only an idle FSM can ack a no-lane write on the next edge.
    do_txn(1, 1'b1, 32'h0000_0004, 32'h0, 4'h0, lat, rd);
    check("l3_cd_idle", 32'(lat), 32'd1);

    check("dat_o_zero_without_ack", 32'(zero_viol), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
